barrel_shift_right: RTL and testbench

- Registered logical right barrel shifter for the mantissa-alignment stage of the floating-point adder.
- Shifts a 23-bit significand right by a 5-bit amount and registers the result.
- Feeds the aligned smaller-exponent operand to the significand adder.

---
 rtl/barrel_shift_right.sv | 81 ++++++++
 tb/tb_barrel_shift_right.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_right.sv
// Registered logical right barrel shifter for FP-add mantissa alignment.
// Define BSR_GRS_EN to add the registered {guard, round, sticky} output.
module barrel_shift_right #(
    parameter int WIDTH = 23,
    parameter int SHW   = 5
) (
    output logic [WIDTH-1:0] out,
    input  logic [SHW-1:0]   sel,
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             reset
`ifdef BSR_GRS_EN
    ,
    output logic [2:0]       grs
`endif
);

    logic [WIDTH-1:0] out_n;

`ifdef BSR_GRS_EN
    // Two extra LSBs catch guard/round; anything falling past them is sticky.
    localparam int EW = WIDTH + 2;

    logic [EW-1:0] ext [SHW+1];
    logic [SHW:0]  stk;
    logic [2:0]    grs_n;

    assign ext[0] = {in, 2'b00};
    assign stk[0] = 1'b0;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 1 << k;
        if (SH >= EW) begin : g_flush
            assign ext[k+1] = sel[k] ? '0 : ext[k];
            assign stk[k+1] = stk[k] | (sel[k] & (|ext[k]));
        end else begin : g_shift
            assign ext[k+1] = sel[k]
                ? {{SH{1'b0}}, ext[k][EW-1:SH]}
                : ext[k];
            assign stk[k+1] = stk[k] | (sel[k] & (|ext[k][SH-1:0]));
        end
    end

    assign out_n = ext[SHW][EW-1:2];
    assign grs_n = {ext[SHW][1:0], stk[SHW]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grs <= '0;
        end else begin
            grs <= grs_n;
        end
    end
`else
    logic [WIDTH-1:0] stg [SHW+1];

    assign stg[0] = in;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 1 << k;
        if (SH >= WIDTH) begin : g_flush
            assign stg[k+1] = sel[k] ? '0 : stg[k];
        end else begin : g_shift
            assign stg[k+1] = sel[k]
                ? {{SH{1'b0}}, stg[k][WIDTH-1:SH]}
                : stg[k];
        end
    end

    assign out_n = stg[SHW];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else begin
            out <= out_n;
        end
    end

endmodule

// File: tb/tb_barrel_shift_right.sv
// Directed + swept bench for barrel_shift_right with a queued scoreboard.
// Handles both builds (BSR_GRS_EN defined or not).
module tb_barrel_shift_right;

    localparam int W = 23;

    typedef struct packed {
        logic [W-1:0] o;
        logic [2:0]   g;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] in;
    logic [4:0]   sel;
    logic [W-1:0] out;
    logic [2:0]   grs_obs;
`ifdef BSR_GRS_EN
    logic [2:0]   grs;
    assign grs_obs = grs;
`else
    assign grs_obs = 3'b000;
`endif

    exp_t sb[$];
    int   total;
    int   passed;

    barrel_shift_right #(.WIDTH(W), .SHW(5)) dut (
        .out   (out),
        .sel   (sel),
        .in    (in),
        .clk   (clk),
        .reset (reset)
`ifdef BSR_GRS_EN
        ,
        .grs   (grs)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [W-1:0] d, input int s);
        exp_t e;
        logic [31:0] wide;
        wide = {9'd0, d};
        e.o = W'(wide >> s);
        e.g = 3'b000;
`ifdef BSR_GRS_EN
        for (int i = 0; i < W; i++) begin
            if (i == s - 1) e.g[2] = d[i];
            if (i == s - 2) e.g[1] = d[i];
            if (i <= s - 3) e.g[0] = e.g[0] | d[i];
        end
`endif
        return e;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input int s);
        in  = d;
        sel = 5'(s);
        sb.push_back(model(d, s));
    endtask

    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_out"}, 32'(out), 32'(e.o));
            check({tag, "_grs"}, 32'(grs_obs), 32'(e.g));
        end
    endtask

    task automatic step(input string tag, input logic [W-1:0] d, input int s);
        @(negedge clk);
        drive(d, s);
        collect(tag);
    endtask

    initial begin
        logic [W-1:0] r;
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        in     = 23'h7FFFFF;
        sel    = 5'd0;

        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_out", 32'(out), 32'd0);
            check("rst_hold_grs", 32'(grs_obs), 32'd0);
        end

        @(negedge clk);
        reset = 1'b1;
        drive(23'h7FFFFF, 0);
        collect("rst_release");

        step("nominal", 23'h72F2F2, 4);
        step("sel0", 23'h400001, 0);
        step("sel22", 23'h400001, 22);
        step("sel23", 23'h7FFFFF, 23);
        step("sel31", 23'h7FFFFF, 31);
        step("sel24_round", 23'h400000, 24);

        step("pipe1", 23'h7FFFFF, 1);
        step("pipe2", 23'h7FFFFF, 2);
        step("pipe3", 23'h7FFFFF, 3);

        // Back-to-back launches without an idle cycle in between.
        @(negedge clk);
        drive(23'h123456, 7);
        collect("b2b_a");
        drive(23'h654321, 9);
        collect("b2b_b");

        step("pre_async", 23'h7FFFFF, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_grs", 32'(grs_obs), 32'd0);
        @(negedge clk);
        in  = 23'h7FFFFF;
        sel = 5'd0;
        @(posedge clk);
        #1;
        check("rst_discard", 32'(out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 23'h0F0F0F, 8);

        for (int n = 0; n < 4; n++) begin
            r = W'($urandom);
            for (int s = 0; s < 32; s++) begin
                step("sweep", r, s);
            end
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
